// File: rtl/score_bcd_sched_pkg.sv
// Shared types and constants for the score BCD conversion scheduler.
package score_pkg;

    localparam int NDIG    = 4;
    localparam int BCD_MAX = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Index 0 is the units digit, NDIG-1 the thousands digit.
    typedef logic [NDIG-1:0][3:0] bcd_digits_t;

    function automatic bcd_digits_t bcd_of(input int unsigned value);
        bcd_digits_t  r;
        int unsigned  v;
        v = value;
        for (int d = 0; d < NDIG; d++) begin
            r[d] = 4'(v % 10);
            v    = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bcd_sched_if.sv
// Request/result bundle between the score display logic and the BCD scheduler.
interface score_bcd_sched_if #(
    parameter int N_REQ = 3,
    parameter int BIN_W = 14,
    parameter int NDIG  = score_pkg::NDIG
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*BIN_W-1:0]   bin_in;
    logic [N_REQ-1:0]         ack;
    logic                     busy;
    logic [$clog2(N_REQ)-1:0] sel;
    logic [NDIG*4-1:0]        bcd_out;
    logic [N_REQ-1:0]         ovf;

    modport master (output req, bin_in, sel, input ack, busy, bcd_out, ovf);
    modport slave  (input req, bin_in, sel, output ack, busy, bcd_out, ovf);
endinterface

// File: rtl/score_bcd_sched_conv.sv
// Serial shift-and-add-3 binary to BCD converter, one iteration per clock.
module bcd_serial_conv
    import score_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output bcd_digits_t      digits,
    output logic             carry10k
);
    localparam int SR_W = NDIG * 4 + BIN_W;
    localparam int IW   = $clog2(BIN_W);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [IW-1:0]   iter;
    logic            running;

    // Nibbles are corrected independently; no carry crosses a digit boundary.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < NDIG; d++) begin
            if (sr[BIN_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr       <= '0;
            iter     <= '0;
            running  <= 1'b0;
            carry10k <= 1'b0;
        end else if (start) begin
            sr       <= {{(NDIG*4){1'b0}}, bin};
            iter     <= '0;
            running  <= 1'b1;
            carry10k <= 1'b0;
        end else if (running) begin
            sr       <= {sr_adj[SR_W-2:0], 1'b0};
            carry10k <= carry10k | sr_adj[SR_W-1];
            iter     <= iter + 1'b1;
            if (iter == IW'(BIN_W - 1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done   = running && (iter == IW'(BIN_W - 1));
    assign digits = sr[SR_W-1 -: NDIG*4];

endmodule

// File: rtl/score_bcd_sched.sv
// Round-robin scheduler sharing one serial BCD converter among display requesters.
// Define BCD_SAT_EN to store 9999 for values above 9999 instead of the value mod 10000.
module score_bcd_sched
    import score_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int BIN_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    score_bcd_sched_if.slave  bus
);
    localparam int GW = $clog2(N_REQ);

    sched_state_t state, next_state;

    logic [GW-1:0]    grant;
    logic [GW-1:0]    cand;
    logic [GW-1:0]    rr_ptr;
    logic             found;
    logic             start;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] ovf_q;
    bcd_digits_t      result [N_REQ];
    bcd_digits_t      store;

    logic             conv_done;
    logic             conv_carry;
    bcd_digits_t      conv_digits;

    // First requesting index at or after rr_ptr in circular order.
    always_comb begin
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                cand  = GW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        ack        = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (conv_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ack[grant] = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    bcd_serial_conv #(.BIN_W(BIN_W)) u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bus.bin_in[int'(cand)*BIN_W +: BIN_W]),
        .done     (conv_done),
        .digits   (conv_digits),
        .carry10k (conv_carry)
    );

`ifdef BCD_SAT_EN
    assign store = conv_carry ? bcd_of(BCD_MAX) : conv_digits;
`else
    assign store = conv_digits;
`endif

    // A ten-thousands carry is exactly the condition value > 9999.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant  <= '0;
            rr_ptr <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                result[i] <= '0;
            end
        end else begin
            if (start) begin
                grant <= cand;
            end
            if (state == DONE) begin
                result[grant] <= store;
                ovf_q[grant]  <= conv_carry;
                rr_ptr        <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    always_comb begin
        bus.bcd_out = '0;
        if (int'(bus.sel) < N_REQ) begin
            bus.bcd_out = result[bus.sel];
        end
    end

    assign bus.ack  = ack;
    assign bus.busy = (state != IDLE);
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_score_bcd_sched.sv
// Directed scoreboard bench for score_bcd_sched: latency, round-robin order, overflow, reset and display select.
module tb_score_bcd_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int idx;
        int val;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] exp_res [3];
    logic        exp_ovf [3];

    score_bcd_sched_if #(.N_REQ(3), .BIN_W(14), .NDIG(4)) bus ();

    score_bcd_sched #(.N_REQ(3), .BIN_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input int v);
        int r;
        r = v;
        if (v > 9999) begin
`ifdef BCD_SAT_EN
            r = 9999;
`else
            r = v % 10000;
`endif
        end
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected grant; the model updates after the storing edge.
    always @(negedge clk) begin
        if (!reset && (|bus.ack)) begin
            total++;
            assert (sb_q.size() > 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_ack observed=%b expected=none", bus.ack);
            end
            if (sb_q.size() > 0) begin
                sb_t e;
                e = sb_q.pop_front();
                check("ack_index", bus.ack, 32'(1 << e.idx));
                @(posedge clk);
                #1;
                exp_res[e.idx] = model(e.val);
                exp_ovf[e.idx] = (e.val > 9999);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_res[i] = 16'h0000;
            exp_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_output();
        for (int s = 0; s < 3; s++) begin
            bus.sel = 2'(s);
            #1;
            check($sformatf("bcd_sel%0d", s), bus.bcd_out, exp_res[s]);
            check($sformatf("ovf%0d", s), bus.ovf[s], exp_ovf[s]);
        end
        bus.sel = 2'd3;
        #1;
        check("bcd_sel_oob", bus.bcd_out, 0);
    endtask

    task automatic wait_ack(output logic [2:0] seen, output int at);
        logic got;
        got  = 1'b0;
        seen = '0;
        at   = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (|bus.ack) begin
                got  = 1'b1;
                seen = bus.ack;
                at   = cyc;
            end
        end
        total++;
        assert (got) else begin
            bad++;
            $error("[TB] FAIL ack_timeout observed=none expected=ack within 60 cycles");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_ack", bus.ack, 0);
        reset = 1'b0;
        clear_model();
        check_output();
    endtask

    task automatic apply_stimulus(input int idx, input int val);
        int         k;
        int         at;
        logic [2:0] seen;
        @(negedge clk);
        bus.bin_in[idx*14 +: 14] = 14'(val);
        bus.req[idx] = 1'b1;
        sb_q.push_back('{idx: idx, val: val});
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus.req[idx] = 1'b0;
        bus.sel      = 2'(idx);
        check("busy_in_shift", bus.busy, 1);
        wait_ack(seen, at);
        check("ack_latency", at - k, 14);
        check("no_early_result", bus.bcd_out, exp_res[idx]);
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        check_output();
    endtask

    initial begin
        int         k;
        int         at;
        int         prev;
        logic [2:0] seen;

        bus.req    = '0;
        bus.bin_in = '0;
        bus.sel    = '0;
        clear_model();

        // Reset state
        do_reset();

        // Single request
        apply_stimulus(0, 1234);
        check("single_value", exp_res[0], 16'h1234);

        // Reset clears stored results, then simultaneous requests with input capture
        do_reset();
        @(negedge clk);
        bus.bin_in = {14'd0, 14'd9999, 14'd5};
        bus.req    = 3'b111;
        sb_q.push_back('{idx: 0, val: 5});
        sb_q.push_back('{idx: 1, val: 9999});
        sb_q.push_back('{idx: 2, val: 0});
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus.bin_in[13:0] = 14'd7777;
        prev = k;
        for (int i = 0; i < 3; i++) begin
            wait_ack(seen, at);
            bus.req = bus.req & ~seen;
            if (i == 0) check("b2b_first_latency", at - k, 14);
            else        check("b2b_spacing", at - prev, 16);
            prev = at;
        end
        @(negedge clk);
        check_output();

        // Fairness between two continuously requesting sources
        @(negedge clk);
        bus.bin_in[14 +: 14] = 14'd42;
        bus.bin_in[28 +: 14] = 14'd777;
        bus.req = 3'b110;
        sb_q.push_back('{idx: 1, val: 42});
        sb_q.push_back('{idx: 2, val: 777});
        sb_q.push_back('{idx: 1, val: 42});
        sb_q.push_back('{idx: 2, val: 777});
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(seen, at);
            if (i > 0) check("fair_spacing", at - prev, 16);
            if (i == 3) bus.req = '0;
            prev = at;
        end
        repeat (3) @(negedge clk);
        check("fair_idle", bus.busy, 0);
        check_output();

        // Overflow boundaries
        apply_stimulus(0, 16383);
        apply_stimulus(1, 10000);
        apply_stimulus(2, 9999);

        // Reset in the middle of a conversion
        @(negedge clk);
        bus.bin_in[13:0] = 14'd321;
        bus.req[0] = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus.req[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_iter_cycle", cyc - k, 7);
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_busy", bus.busy, 0);
        check("mid_reset_ack", bus.ack, 0);
        clear_model();
        check_output();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_reset_quiet", bus.busy, 0);
        apply_stimulus(2, 4321);
        check("post_reset_value", exp_res[2], 16'h4321);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=still running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
